dm_store_buf: RTL
=================

DM_STORE_BUF -- requirements
Module: dm_store_buf

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 sampled at rising clk edge).
REQ-003 SHALL have port st_valid  input  1  store request present.
REQ-004 SHALL have port st_ready  output  1  buffer can accept a request this cycle.
REQ-005 SHALL have port st_addr  input  32  byte address of store.
REQ-006 SHALL have port st_data  input  32  register data; low byte/half used for SB/SH.
REQ-007 SHALL have port storeOp  input  2  00 SW, 01 SH, 10 SB, 11 reserved.
REQ-008 SHALL have port misalign  output  1  registered one-cycle error pulse.
REQ-009 SHALL have port mem_valid  output  1  write beat presented to data memory.
REQ-010 SHALL have port mem_ready  input  1  memory accepts beat.
REQ-011 SHALL have port mem_addr  output  32  word address; bits [1:0] always 0.
REQ-012 SHALL have port mem_wdata  output  32  lane-aligned write data.
REQ-013 SHALL have port mem_be  output  4  byte enables; bit i covers mem_wdata[8i+7:8i].
REQ-014 SHALL have port ld_addr  input  32  load address for hazard check.
REQ-015 SHALL have port ld_hit  output  1  combinational: buffered entry covers same word as ld_addr.
REQ-016 SHALL have port empty  output  1  no entries buffered.

Function
REQ-017 SHALL hold a 2-entry FIFO of {word addr, wdata, be}; st_ready = (count<2), independent of mem_ready (no pass-through when full).
REQ-018 SHALL accept a request when st_valid && st_ready at a rising edge.
REQ-019 SHALL, on acceptance, reject (not enqueue) SW with addr[1:0]!=0, SH with addr[0]!=0, and storeOp==11; misalign SHALL be 1 for exactly the next cycle.
REQ-020 SHALL encode little-endian lanes: SW be=1111, wdata=st_data; SH be=0011 (addr[1]=0) or 1100 (addr[1]=1), wdata={2{st_data[15:0]}}; SB be=0001<<addr[1:0], wdata={4{st_data[7:0]}}.
REQ-021 SHALL drive mem_valid=1 whenever count>0, presenting the FIFO head; an entry accepted at edge N is visible on mem_* from cycle N+1.
REQ-022 SHALL keep mem_addr/mem_wdata/mem_be stable while mem_valid && !mem_ready.
REQ-023 SHALL pop the head when mem_valid && mem_ready at a rising edge; head advances to next entry the following cycle.
REQ-024 SHALL, on simultaneous push and pop, keep count unchanged and preserve order.
REQ-025 SHALL drive mem_wdata=0, mem_be=0, mem_addr=0 when count==0.
REQ-026 SHALL assert ld_hit when any valid entry has mem_addr[31:2]==ld_addr[31:2]; 0 when empty.
REQ-027 SHALL implement pointers as 1-bit wrapping indices plus 2-bit count (0..2); count never exceeds 2 or underflows.
REQ-028 SHALL assert empty = (count==0).

Reset
REQ-029 SHALL, when reset==0 at a rising edge, clear count, pointers and misalign; next cycle mem_valid=0, empty=1, st_ready=1, mem_be=0, ld_hit=0.
REQ-030 SHALL discard buffered entries and any in-flight beat if reset occurs mid-operation, ignoring st_valid and mem_ready that edge.

Verification
REQ-031 SB addr=0x00000013 data=0x000000AB, mem_ready=1 -> next cycle mem_addr=0x10, be=1000, wdata=0xABABABAB, mem_valid=1 for one cycle.
REQ-032 SH addr=0x102, data=0x1234 then SW addr=0x200, data=0xDEADBEEF with mem_ready=0 -> st_ready=0 after second accept; raising mem_ready drains be=1100/0x12341234 then be=1111/0xDEADBEEF, in order.
REQ-033 SW addr=0x101 -> not enqueued, misalign=1 exactly one cycle, empty stays 1; same for storeOp=11.
REQ-034 Count=1, mem_ready=1, st_valid=1 same edge -> count stays 1, no beat lost or duplicated.
REQ-035 Buffer holds SW to 0x40, ld_addr=0x43 -> ld_hit=1; ld_addr=0x44 -> ld_hit=0.
REQ-036 Two entries buffered, reset=0 one edge -> mem_valid=0, empty=1, st_ready=1 next cycle; no subsequent beats emitted.

Source files
------------

// File: rtl/dm_store_buf.sv
// Two-entry store buffer between the pipeline and data memory. It encodes
// SW/SH/SB into lane-aligned beats, drains them in order and flags load hazards.
module dm_store_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [1:0]  storeOp,
   output logic        misalign,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] ld_addr,
   output logic        ld_hit,
   output logic        empty
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never depends on ready, and payload holds while valid && !ready.

   logic [29:0] ent_addr [2];
   logic [31:0] ent_data [2];
   logic [3:0]  ent_be   [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic        nxt_ptr;
   logic [1:0]  count;

   logic        bad;
   logic [3:0]  enc_be;
   logic [31:0] enc_data;
   logic        accept;
   logic        push;
   logic        pop;
   logic        unused_ld_low;

   always_comb begin
      bad      = 1'b0;
      enc_be   = 4'b0000;
      enc_data = 32'h0;
      case (storeOp)
         2'b00: begin
            bad      = (st_addr[1:0] != 2'b00);
            enc_be   = 4'b1111;
            enc_data = st_data;
         end
         2'b01: begin
            bad      = st_addr[0];
            enc_be   = st_addr[1] ? 4'b1100 : 4'b0011;
            enc_data = {2{st_data[15:0]}};
         end
         2'b10: begin
            enc_be   = 4'b0001 << st_addr[1:0];
            enc_data = {4{st_data[7:0]}};
         end
         default: bad = 1'b1;
      endcase
   end

   assign st_ready  = (count != 2'd2);
   assign accept    = st_valid && st_ready;
   assign push      = accept && !bad;
   assign mem_valid = (count != 2'd0);
   assign pop       = mem_valid && mem_ready;
   assign empty     = (count == 2'd0);
   assign nxt_ptr   = rd_ptr ^ 1'b1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count    <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         misalign <= 1'b0;
      end else begin
         misalign <= accept && bad;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset: count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (reset && push) begin
         ent_addr[wr_ptr] <= st_addr[31:2];
         ent_data[wr_ptr] <= enc_data;
         ent_be[wr_ptr]   <= enc_be;
      end
   end

   assign mem_addr  = mem_valid ? {ent_addr[rd_ptr], 2'b00} : 32'h0;
   assign mem_wdata = mem_valid ? ent_data[rd_ptr] : 32'h0;
   assign mem_be    = mem_valid ? ent_be[rd_ptr] : 4'b0000;

   // Only the word index matters for a hazard; byte offset bits are ignored.
   assign ld_hit = ((count != 2'd0) && (ent_addr[rd_ptr]  == ld_addr[31:2])) ||
                   ((count == 2'd2) && (ent_addr[nxt_ptr] == ld_addr[31:2]));
   assign unused_ld_low = ^ld_addr[1:0];

endmodule
